// File: rtl/wb_arbiter_pkg.sv
// Shared register-file types for the writeback path.
package mips_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Field is "rd" because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback sources, register-file write port and forwarding lookups.
interface wb_arbiter_if import mips_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
);
  logic              a_valid;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic              regWrite;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CW-1:0]     fifo_count;
  logic [REG_W-1:0]  q1_reg;
  logic              q1_hit;
  logic [DATA_W-1:0] q1_data;
  logic [REG_W-1:0]  q2_reg;
  logic              q2_hit;
  logic [DATA_W-1:0] q2_data;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, q1_reg, q2_reg,
    output b_ready, regWrite, write_reg, write_data, fifo_count,
           q1_hit, q1_data, q2_hit, q2_data
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, q1_reg, q2_reg,
    input  b_ready, regWrite, write_reg, write_data, fifo_count,
           q1_hit, q1_data, q2_hit, q2_data
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// Source-B result queue; exposes entries oldest-first with a valid mask.
module wb_fifo import mips_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  wb_req_t                 i_din,
  input  logic                    i_pop,
  output wb_req_t                 o_head,
  output logic [CW-1:0]           o_count,
  output wb_req_t [DEPTH-1:0]     o_entries,
  output logic [DEPTH-1:0]        o_valid
);
  localparam int PW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wr_ptr] <= i_din;
  end

  // Rotate storage so index 0 is the head; higher index means younger.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_entries[k] = r_mem[r_rd_ptr + PW'(k)];
      o_valid[k]   = (CW'(k) < r_count);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline WB (A) and long-latency results (B) onto the single
// register-file write port, with forwarding over not-yet-committed writes.
module wb_arbiter import mips_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_if.slave     bus
);
  wb_req_t              w_head;
  wb_req_t [DEPTH-1:0]  w_entries;
  logic [DEPTH-1:0]     w_valid;
  logic [CW-1:0]        w_count;
  logic w_a_eff, w_b_ready, w_b_fire, w_b_eff, w_fifo_ne;
  logic w_pop, w_bypass, w_push;
  logic [DATA_W:0] w_fwd1, w_fwd2;

  wb_req_t r_out;
  logic    r_wr_en;

  assign w_a_eff   = bus.a_valid && (bus.a_reg != REG_ZERO);
  assign w_b_ready = !rst && (w_count < CW'(DEPTH));
  assign w_b_fire  = bus.b_valid && w_b_ready;
  assign w_b_eff   = w_b_fire && (bus.b_reg != REG_ZERO);
  assign w_fifo_ne = (w_count != '0);
  assign w_pop     = !w_a_eff && w_fifo_ne;
  assign w_bypass  = !w_a_eff && !w_fifo_ne && w_b_eff;
  assign w_push    = w_b_eff && !w_bypass;

  wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_din     ('{rd: bus.b_reg, data: bus.b_data}),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // Address/data hold on idle cycles; only the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en <= 1'b0;
      r_out   <= '0;
    end else if (w_a_eff) begin
      r_wr_en <= 1'b1;
      r_out   <= '{rd: bus.a_reg, data: bus.a_data};
    end else if (w_pop) begin
      r_wr_en <= 1'b1;
      r_out   <= w_head;
    end else if (w_bypass) begin
      r_wr_en <= 1'b1;
      r_out   <= '{rd: bus.b_reg, data: bus.b_data};
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  // Later matches override earlier ones: output stage, then FIFO oldest->newest.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [REG_W-1:0]  q,
    input logic              out_v,
    input wb_req_t           out,
    input wb_req_t [DEPTH-1:0] ent,
    input logic [DEPTH-1:0]  vld
  );
    logic [DATA_W:0] res;
    res = '0;
    if (q != REG_ZERO) begin
      if (out_v && out.rd == q) res = {1'b1, out.data};
      for (int k = 0; k < DEPTH; k++)
        if (vld[k] && ent[k].rd == q) res = {1'b1, ent[k].data};
    end
    return res;
  endfunction

  assign w_fwd1 = fwd_lookup(bus.q1_reg, r_wr_en, r_out, w_entries, w_valid);
  assign w_fwd2 = fwd_lookup(bus.q2_reg, r_wr_en, r_out, w_entries, w_valid);

  assign bus.b_ready    = w_b_ready;
  assign bus.regWrite   = r_wr_en;
  assign bus.write_reg  = r_out.rd;
  assign bus.write_data = r_out.data;
  assign bus.fifo_count = w_count;
  assign bus.q1_hit     = w_fwd1[DATA_W];
  assign bus.q1_data    = w_fwd1[DATA_W-1:0];
  assign bus.q2_hit     = w_fwd2[DATA_W];
  assign bus.q2_data    = w_fwd2[DATA_W-1:0];
endmodule
